// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage data access unit: access sizes, exception
// causes and controller states.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B    = 2'b00,
    MEM_H    = 2'b01,
    MEM_W    = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISALIGN = 2'd1,
    RANGE    = 2'd2,
    ILLEGAL  = 2'd3
  } exc_cause_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: extracts and extends a load lane from a RAM word,
// and builds the merged word for a sub-word store.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Byte offset 0 is the most significant byte of the word.
  always_comb begin
    byte_lane = word[31:24];
    case (offset)
      2'd0: byte_lane = word[31:24];
      2'd1: byte_lane = word[23:16];
      2'd2: byte_lane = word[15:8];
      2'd3: byte_lane = word[7:0];
      default: byte_lane = word[31:24];
    endcase
    half_lane = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    load_data = word;
    case (size)
      MEM_B: load_data = is_signed ? {{24{byte_lane[7]}}, byte_lane} : {24'd0, byte_lane};
      MEM_H: load_data = is_signed ? {{16{half_lane[15]}}, half_lane} : {16'd0, half_lane};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged_word = word;
    case (size)
      MEM_B: begin
        case (offset)
          2'd0: merged_word = {new_data[7:0], word[23:0]};
          2'd1: merged_word = {word[31:24], new_data[7:0], word[15:0]};
          2'd2: merged_word = {word[31:16], new_data[7:0], word[7:0]};
          2'd3: merged_word = {word[31:8], new_data[7:0]};
          default: merged_word = word;
        endcase
      end
      MEM_H: merged_word = offset[1] ? {word[31:16], new_data[15:0]}
                                     : {new_data[15:0], word[15:0]};
      MEM_W: merged_word = new_data;
      default: merged_word = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: checks requests, performs loads with extension, word
// stores directly and sub-word stores as a two-cycle read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  exc_valid,
  output logic [1:0]            exc_cause,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  mem_state_e            state;
  exc_cause_e            cause;
  logic                  accept;
  logic                  legal;
  logic [ADDR_WIDTH-1:0] rmw_addr;
  logic [31:0]           rmw_data;
  logic [31:0]           load_data;
  logic [31:0]           merged_word;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Checks in priority order: out of range, reserved size, misalignment.
  always_comb begin
    cause = NONE;
    if (|req_addr[31:ADDR_WIDTH])
      cause = RANGE;
    else if (req_size == MEM_RSVD)
      cause = ILLEGAL;
    else if ((req_size == MEM_H && req_addr[0]) ||
             (req_size == MEM_W && req_addr[1:0] != 2'b00))
      cause = MISALIGN;
  end

  assign legal = (cause == NONE);

  mem_lane_align u_align (
    .word        (ram_rdata),
    .offset      (req_addr[1:0]),
    .size        (req_size),
    .is_signed   (req_signed),
    .new_data    (req_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  assign ram_addr  = (state == RMW_WR) ? rmw_addr : {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign ram_wdata = (state == RMW_WR) ? rmw_data : req_wdata;

  // Reset masks the write so an interrupted read-modify-write leaves RAM intact.
  always_comb begin
    ram_write = 1'b0;
    if (!rst) begin
      if (state == RMW_WR)
        ram_write = 1'b1;
      else if (accept && legal && req_write && req_size == MEM_W)
        ram_write = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      exc_valid  <= 1'b0;
      exc_cause  <= NONE;
      rmw_addr   <= '0;
      rmw_data   <= '0;
    end else begin
      resp_valid <= 1'b0;
      exc_valid  <= 1'b0;
      exc_cause  <= NONE;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!legal) begin
              exc_valid <= 1'b1;
              exc_cause <= cause;
            end else if (!req_write) begin
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
            end else if (req_size != MEM_W) begin
              rmw_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              rmw_data <= merged_word;
              state    <= RMW_WR;
            end
          end
        end
        RMW_WR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural
// big-endian word RAM attached to its RAM port.
module tb_mem_access_unit;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [AW-1:0] ram_addr;
  logic        ram_write;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[AW-1:2]];

  always @(posedge clk) begin
    if (ram_write) mem[ram_addr[AW-1:2]] <= ram_wdata;
  end

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .exc_valid  (exc_valid),
    .exc_cause  (exc_cause),
    .ram_addr   (ram_addr),
    .ram_write  (ram_write),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Inputs change 1 time unit after the rising edge; registered outputs are
  // sampled at the same point, combinational outputs at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    put(1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ready got %b exp 0", req_ready); end
    n_checks++; if (ram_write !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ram_write got %b exp 0", ram_write); end
    step();
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_resp_valid got %b exp 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_resp_rdata got %h exp 0", resp_rdata); end
    n_checks++; if (exc_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_exc_valid got %b exp 0", exc_valid); end
    n_checks++; if (exc_cause !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_exc_cause got %0d exp 0", exc_cause); end
    n_checks++; if (mem[12] === 32'h12345678) begin n_fail++; $display("[TB] FAIL rst_no_write got %h exp not 12345678", mem[12]); end
    idle();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_ready got %b exp 1", req_ready); end
    step();
  endtask

  task automatic test_back_to_back();
    put(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
    @(negedge clk);
    n_checks++; if (ram_write !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_write got %b exp 1", ram_write); end
    n_checks++; if (ram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL sw_wdata got %h exp deadbeef", ram_wdata); end
    n_checks++; if (ram_addr !== 10'h20) begin n_fail++; $display("[TB] FAIL sw_addr got %h exp 020", ram_addr); end
    step();
    put(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_no_stall got %b exp 1", req_ready); end
    n_checks++; if (ram_write !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_write got %b exp 0", ram_write); end
    step();
    idle();
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_valid got %b exp 1", resp_valid); end
    n_checks++; if (resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL lw_data got %h exp deadbeef", resp_rdata); end
    step();
  endtask

  task automatic test_load_ext();
    logic [1:0]  sz  [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    logic        sg  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] ad  [8] = '{32'h10, 32'h10, 32'h12, 32'h10, 32'h10, 32'h13, 32'h11, 32'h10};
    logic [31:0] exp [8] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'hFFFF80FF,
                             32'h000080FF, 32'h00000001, 32'hFFFFFFFF, 32'h80FF7F01};
    put(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01);
    step();
    for (int i = 0; i < 8; i++) begin
      put(1'b0, sz[i], sg[i], ad[i], 32'h0);
      step();
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL load_%0d got valid=%b data=%h exp valid=1 data=%h", i, resp_valid, resp_rdata, exp[i]);
      end
    end
    idle();
    step();
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL load_pulse got %b exp 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h80FF7F01) begin n_fail++; $display("[TB] FAIL load_hold got %h exp 80ff7f01", resp_rdata); end
  endtask

  task automatic test_rmw();
    put(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    step();
    put(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAB);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || ram_write !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_accept got ready=%b write=%b exp ready=1 write=0", req_ready, ram_write); end
    step();
    put(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_stall got %b exp 0", req_ready); end
    n_checks++; if (ram_write !== 1'b1 || ram_wdata !== 32'h1122AB44 || ram_addr !== 10'h10) begin
      n_fail++; $display("[TB] FAIL sb_rmw got write=%b data=%h addr=%h exp 1 1122ab44 010", ram_write, ram_wdata, ram_addr); end
    step();
    n_checks++; if (mem[4] !== 32'h1122AB44) begin n_fail++; $display("[TB] FAIL sb_mem got %h exp 1122ab44", mem[4]); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_resp got %b exp 0", resp_valid); end
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || ram_write !== 1'b0) begin n_fail++; $display("[TB] FAIL sh_accept got ready=%b write=%b exp ready=1 write=0", req_ready, ram_write); end
    step();
    idle();
    @(negedge clk);
    n_checks++; if (ram_write !== 1'b1 || ram_wdata !== 32'hBEEFAB44) begin n_fail++; $display("[TB] FAIL sh_rmw got write=%b data=%h exp 1 beefab44", ram_write, ram_wdata); end
    step();
    put(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    step();
    idle();
    n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hBEEFAB44) begin n_fail++; $display("[TB] FAIL sh_readback got valid=%b data=%h exp 1 beefab44", resp_valid, resp_rdata); end
    step();
  endtask

  task automatic test_exceptions();
    logic        wr  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sz  [6] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10};
    logic [31:0] ad  [6] = '{32'h11, 32'h22, 32'h400, 32'h10, 32'h21, 32'h401};
    logic [1:0]  exp [6] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
    for (int i = 0; i < 6; i++) begin
      put(wr[i], sz[i], 1'b0, ad[i], 32'h55555555);
      @(negedge clk);
      n_checks++; if (ram_write !== 1'b0) begin n_fail++; $display("[TB] FAIL exc_write_%0d got %b exp 0", i, ram_write); end
      step();
      n_checks++;
      if (exc_valid !== 1'b1 || exc_cause !== exp[i] || resp_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL exc_%0d got valid=%b cause=%0d resp=%b exp 1 %0d 0", i, exc_valid, exc_cause, resp_valid, exp[i]);
      end
    end
    idle();
    step();
    n_checks++; if (exc_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL exc_pulse got %b exp 0", exc_valid); end
    n_checks++; if (mem[8] !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL exc_mem got %h exp deadbeef", mem[8]); end
    n_checks++; if (mem[0] === 32'h55555555) begin n_fail++; $display("[TB] FAIL exc_range_mem got %h exp not 55555555", mem[0]); end
  endtask

  task automatic test_reset_during_rmw();
    put(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344);
    step();
    put(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000CD);
    step();
    idle();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (ram_write !== 1'b0) begin n_fail++; $display("[TB] FAIL rmw_rst_write got %b exp 0", ram_write); end
    step();
    n_checks++; if (mem[12] !== 32'h11223344) begin n_fail++; $display("[TB] FAIL rmw_rst_mem got %h exp 11223344", mem[12]); end
    n_checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || exc_valid !== 1'b0 || exc_cause !== 2'd0) begin
      n_fail++; $display("[TB] FAIL rmw_rst_outs got %b %h %b %0d exp 0 0 0 0", resp_valid, resp_rdata, exc_valid, exc_cause); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || ram_write !== 1'b0) begin n_fail++; $display("[TB] FAIL rmw_rst_idle got ready=%b write=%b exp 1 0", req_ready, ram_write); end
    step();
    put(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    step();
    idle();
    n_checks++; if (resp_rdata !== 32'h11223344) begin n_fail++; $display("[TB] FAIL rmw_rst_readback got %h exp 11223344", resp_rdata); end
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    step();
    step();
    test_reset();
    test_back_to_back();
    test_load_ext();
    test_rmw();
    test_exceptions();
    test_reset_during_rmw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
